fp_convert_unit: RTL and testbench
==================================

# fp_convert_unit

Multi-cycle conversion unit for RV32F conversions (fcvt.w.s, fcvt.wu.s, fcvt.s.w, fcvt.s.wu). It sits beside the main ALU, downstream of the ALU decoder, and consumes its 5-bit ALUControl conversion codes. Each conversion is a bit-serial iterative shift (one bit per cycle) instead of a wide combinational shifter. While a conversion runs, the unit stalls the single-cycle core.

## Interface
- No parameters.
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request from the current instruction.
- alu_control  input  5  ALU decoder code:
  - 10100 fcvt.wu.s
  - 10101 fcvt.w.s
  - 10110 fcvt.s.wu
  - 10111 fcvt.s.w
  - any other code: ignored.
- src_a  input  32  operand: FP bit pattern (float→int) or integer (int→float).
- stall  output  1  freezes PC and register writes while high.
- busy  output  1  high in SHIFT and PACK.
- done  output  1  one-cycle pulse; result and invalid are valid.
- result  output  32  converted value; held until the next accepted start.
- invalid  output  1  NV flag; valid with done.

## Operation
- States: IDLE, SHIFT, PACK, DONE.
- **Accept rule**
  - In IDLE with start=1 and a conversion code, the operand is captured, classified and decoded at the clock edge.
  - start is ignored in any other state, and ignored for non-conversion codes.
- **Float→int** (RTZ rounding). Fields: s, e, m={1,frac}.
  - NaN (e=255, frac≠0): result 0x7FFFFFFF signed, 0xFFFFFFFF unsigned; invalid=1.
  - e<127 (|x|<1, including zeros and denormals): result 0; invalid=0.
  - Signed overflow (e≥158, including ±inf): result 0x80000000 if s=1, else 0x7FFFFFFF. invalid=1, except for exact -2^31.
  - Unsigned overflow (e≥159, s=0): result 0xFFFFFFFF; invalid=1.
  - Unsigned with s=1 and e≥127: result 0; invalid=1.
  - The cases above are trivial: go directly to DONE.
  - Otherwise: acc = m zero-extended to 32 bits, n = |e-150|.
    - SHIFT shifts acc one bit per cycle for n cycles: left if e>150, right if e<150.
    - PACK applies two's-complement negation when s=1 (signed only).
- **Int→float** (RNE rounding).
  - Magnitude = |src_a| for signed (0x80000000 gives magnitude 0x80000000), raw value for unsigned.
  - Zero: trivial, result 0x00000000.
  - SHIFT left-shifts acc one bit per cycle until acc[31]=1, counting k shifts.
  - PACK:
    - exponent = 158-k; mantissa = acc[30:8]; guard = acc[7]; sticky = |acc[6:0].
    - Round up when guard & (sticky | mantissa[0]).
    - If the mantissa carries out: exponent+1, mantissa 0.
    - Sign = s (signed only).
    - invalid is always 0.
- **Transitions**
  - IDLE→DONE for trivial cases.
  - IDLE→PACK when n=0 (float→int with e=150, or int→float with acc[31] already set).
  - IDLE→SHIFT otherwise.
  - SHIFT→PACK after the last shift.
  - PACK→DONE.
  - DONE→IDLE.
- Shift counter: 5 bits; n≤23 for float→int, k≤31 for int→float.

## Timing
- Reset: state IDLE; result 0; done 0; invalid 0; busy 0; stall 0.
- Reset mid-conversion aborts the conversion immediately. No done is produced.
- stall is combinational: (IDLE & start & conversion code) | SHIFT | PACK. It is low in DONE, so the core writes result at the DONE edge and advances.
- Latency, counting the start cycle as cycle 0, done is high in:
  - cycle 1 for trivial cases;
  - cycle n+2 otherwise (n = shift count).
- Worst case: int→float of 1 gives done in cycle 33.
- busy is low in IDLE and DONE.
- A start in the DONE cycle is ignored. The next request is accepted in IDLE.

## Test plan
- fcvt.w.s, src_a=0xC0490FDB (-3.14159): n=22; done in cycle 24; result 0xFFFFFFFD; invalid=0; stall high in cycles 0-23.
- fcvt.wu.s, src_a=0x4F800000 (2^32): done in cycle 1; result 0xFFFFFFFF; invalid=1. Repeat with 0x7FC00000 (NaN) → 0xFFFFFFFF, invalid=1. Repeat with 0xBF800000 (-1.0) → 0, invalid=1.
- fcvt.s.w, src_a=0x00000001: k=31; done in cycle 33; result 0x3F800000.
- fcvt.s.wu, src_a=0xFFFFFFFF: done in cycle 2; rounding carry gives result 0x4F800000.
- fcvt.s.w, src_a=0x80000000: done in cycle 2; result 0xCF000000. Then src_a=0x00000000: done in cycle 1; result 0.
- Boundary controls:
  - Pulse rst_n low in cycle 5 of the 0x00000001 conversion: all outputs 0, no done.
  - Assert start with alu_control=00000: no stall, no busy.
  - Assert start while busy: ignored; the running result is unchanged.

Source files
------------

// File: rtl/fp_convert_unit.sv
// RV32F fcvt.{w,wu}.s / fcvt.s.{w,wu} unit using a one-bit-per-cycle shifter instead of a barrel shifter.
// done after 1 cycle (trivial) or n+2 cycles; stall holds the core from the accepting cycle until DONE.
module fp_convert_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  alu_control,
    input  logic [31:0] src_a,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PACK, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_f2i;
    logic        r_neg;
    logic        r_left;
    logic        r_invalid;
    logic [31:0] r_acc;
    logic [31:0] r_result;
    logic [4:0]  r_cnt;

    logic        w_is_conv;
    logic        w_accept;
    logic        w_f2i;
    logic        w_signed;
    logic        w_s;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_neg;

    logic        w_f_triv;
    logic        w_f_inv;
    logic [31:0] w_f_res;
    logic        w_f_left;
    logic [4:0]  w_f_n;
    logic [31:0] w_i_mag;

    logic        w_triv;
    logic        w_triv_inv;
    logic [31:0] w_triv_res;
    logic        w_no_shift;
    logic        w_shift_last;

    logic [7:0]  w_i_exp;
    logic        w_round;
    logic [23:0] w_mant_r;
    logic [31:0] w_i_res;
    logic [31:0] w_f_pack;
    logic [31:0] w_pack_res;

    assign w_is_conv = (alu_control[4:2] == 3'b101);
    assign w_accept  = (r_state == S_IDLE) && start && w_is_conv;
    assign w_f2i     = !alu_control[1];
    assign w_signed  = alu_control[0];
    assign w_s       = src_a[31];
    assign w_exp     = src_a[30:23];
    assign w_frac    = src_a[22:0];
    assign w_neg     = w_signed && w_s;

    // Saturating / zero cases that never need the shifter.
    always_comb begin
        w_f_triv = 1'b1;
        w_f_inv  = 1'b0;
        w_f_res  = 32'd0;
        if (w_exp == 8'hFF && w_frac != 23'd0) begin
            w_f_res = w_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            w_f_inv = 1'b1;
        end else if (w_exp < 8'd127) begin
            w_f_res = 32'd0;
        end else if (w_signed) begin
            if (w_exp >= 8'd158) begin
                w_f_res = w_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                w_f_inv = !(w_s && w_exp == 8'd158 && w_frac == 23'd0);
            end else begin
                w_f_triv = 1'b0;
            end
        end else if (w_s) begin
            w_f_inv = 1'b1;
        end else if (w_exp >= 8'd159) begin
            w_f_res = 32'hFFFF_FFFF;
            w_f_inv = 1'b1;
        end else begin
            w_f_triv = 1'b0;
        end
    end

    // |e-150| is below 32 on the shifting path, so modulo-32 arithmetic on e[4:0] suffices.
    assign w_f_left   = (w_exp > 8'd150);
    assign w_f_n      = w_f_left ? (w_exp[4:0] - 5'd22) : (5'd22 - w_exp[4:0]);
    assign w_i_mag    = w_neg ? (~src_a + 32'd1) : src_a;

    assign w_triv     = w_f2i ? w_f_triv : (w_i_mag == 32'd0);
    assign w_triv_res = w_f2i ? w_f_res : 32'd0;
    assign w_triv_inv = w_f2i && w_f_inv;
    assign w_no_shift = w_f2i ? (w_f_n == 5'd0) : w_i_mag[31];
    assign w_shift_last = r_f2i ? (r_cnt == 5'd1) : r_acc[30];

    assign w_i_exp    = 8'd158 - {3'b000, r_cnt};
    assign w_round    = r_acc[7] && ((|r_acc[6:0]) || r_acc[8]);
    assign w_mant_r   = {1'b0, r_acc[30:8]} + {23'd0, w_round};
    assign w_i_res    = {r_neg,
                         w_mant_r[23] ? (w_i_exp + 8'd1) : w_i_exp,
                         w_mant_r[23] ? 23'd0 : w_mant_r[22:0]};
    assign w_f_pack   = r_neg ? (~r_acc + 32'd1) : r_acc;
    assign w_pack_res = r_f2i ? w_f_pack : w_i_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_triv) begin
                        w_next = S_DONE;
                    end else if (w_no_shift) begin
                        w_next = S_PACK;
                    end else begin
                        w_next = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_next = S_PACK;
                end
            end
            S_PACK:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f2i     <= 1'b0;
            r_neg     <= 1'b0;
            r_left    <= 1'b0;
            r_acc     <= 32'd0;
            r_cnt     <= 5'd0;
            r_result  <= 32'd0;
            r_invalid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_f2i <= w_f2i;
                r_neg <= w_neg;
                if (w_f2i) begin
                    r_acc  <= {8'd0, 1'b1, w_frac};
                    r_cnt  <= w_f_n;
                    r_left <= w_f_left;
                end else begin
                    r_acc  <= w_i_mag;
                    r_cnt  <= 5'd0;
                    r_left <= 1'b1;
                end
                if (w_triv) begin
                    r_result  <= w_triv_res;
                    r_invalid <= w_triv_inv;
                end
            end else if (r_state == S_SHIFT) begin
                r_acc <= r_left ? {r_acc[30:0], 1'b0} : {1'b0, r_acc[31:1]};
                r_cnt <= r_f2i ? (r_cnt - 5'd1) : (r_cnt + 5'd1);
            end else if (r_state == S_PACK) begin
                r_result  <= w_pack_res;
                r_invalid <= 1'b0;
            end
        end
    end

    assign busy    = (r_state == S_SHIFT) || (r_state == S_PACK);
    assign stall   = w_accept || busy;
    assign done    = (r_state == S_DONE);
    assign result  = r_result;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_fp_convert_unit.sv
// Bench for fp_convert_unit: directed vector table, corner sequences, and random runs against a value-level model.
module tb_fp_convert_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  alu_control;
    logic [31:0] src_a;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;

    int n_pass  = 0;
    int n_total = 0;

    fp_convert_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .alu_control(alu_control),
        .src_a      (src_a),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .invalid    (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] src;
        logic [31:0] res;
        logic        inv;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: evaluates the conversion on numeric values, not on the hardware's datapath.
    function automatic void model(input logic [4:0] ctl, input logic [31:0] x,
                                  output logic [31:0] res, output logic inv, output int lat);
        logic        sgn;
        logic        s;
        logic        nan;
        logic        huge;
        logic        neg;
        logic [63:0] mag;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        int          e;
        int          d;
        int          p;
        int          sh;
        sgn = ctl[0];
        s   = x[31];
        res = 32'd0;
        inv = 1'b0;
        lat = 1;
        if (ctl[1] == 1'b0) begin
            e    = int'(x[30:23]);
            nan  = (e == 255) && (x[22:0] != 23'd0);
            huge = (e == 255) || (e > 180);
            mag  = 64'd0;
            if (!huge) begin
                if (e >= 150) mag = {40'd0, 1'b1, x[22:0]} << (e - 150);
                else          mag = {40'd0, 1'b1, x[22:0]} >> (150 - e);
            end
            d = e - 150;
            if (d < 0) d = -d;
            if (nan) begin
                res = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
                inv = 1'b1;
            end else if (sgn) begin
                if (!huge && mag < 64'h8000_0000) begin
                    res = mag[31:0];
                    if (s) res = -res;
                    if (mag != 64'd0) lat = d + 2;
                end else if (!huge && s && mag == 64'h8000_0000) begin
                    res = 32'h8000_0000;
                end else begin
                    res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    inv = 1'b1;
                end
            end else if (s) begin
                res = 32'd0;
                inv = huge || (mag != 64'd0);
            end else if (!huge && mag <= 64'hFFFF_FFFF) begin
                res = mag[31:0];
                if (mag != 64'd0) lat = d + 2;
            end else begin
                res = 32'hFFFF_FFFF;
                inv = 1'b1;
            end
        end else begin
            neg = sgn && s;
            mag = neg ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
            if (mag != 64'd0) begin
                p = 0;
                for (int b = 0; b < 32; b++) if (mag[b]) p = b;
                lat = 33 - p;
                if (p <= 23) begin
                    q = mag << (23 - p);
                end else begin
                    sh   = p - 23;
                    q    = mag >> sh;
                    rem  = mag - (q << sh);
                    half = 64'd1 << (sh - 1);
                    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
                    if (q == (64'd1 << 24)) begin
                        q = q >> 1;
                        p = p + 1;
                    end
                end
                res = {neg, 8'(127 + p), q[22:0]};
            end
        end
    endfunction

    // Issues one request and follows it to done, checking latency, stall/busy profile and outputs.
    task automatic run_conv(input string nm, input logic [4:0] ctl, input logic [31:0] src,
                            input logic [31:0] e_res, input logic e_inv, input int e_lat);
        int got_lat;
        int prof_err;
        got_lat  = -1;
        prof_err = 0;
        @(negedge clk);
        start       = 1'b1;
        alu_control = ctl;
        src_a       = src;
        #1;
        if (stall !== 1'b1 || busy !== 1'b0) prof_err++;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (stall !== (c < e_lat) || busy !== (c < e_lat)) prof_err++;
            if (done === 1'b1) begin
                got_lat = c;
                break;
            end
        end
        chk({nm, "_latency"}, 32'(got_lat), 32'(e_lat));
        chk({nm, "_result"}, result, e_res);
        chk({nm, "_invalid"}, {31'd0, invalid}, {31'd0, e_inv});
        chk({nm, "_stall_busy"}, 32'(prof_err), 32'd0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [4:0]  r_ctl;
        logic [31:0] r_src;
        logic [31:0] m_res;
        logic        m_inv;
        int          m_lat;
        int          lat_seen;
        int          err;

        vecs.push_back('{5'b10101, 32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 24});
        vecs.push_back('{5'b10100, 32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1});
        vecs.push_back('{5'b10100, 32'h7FC0_0000, 32'hFFFF_FFFF, 1'b1, 1});
        vecs.push_back('{5'b10100, 32'hBF80_0000, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{5'b10111, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33});
        vecs.push_back('{5'b10110, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b0, 2});
        vecs.push_back('{5'b10111, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2});
        vecs.push_back('{5'b10111, 32'h0000_0000, 32'h0000_0000, 1'b0, 1});
        vecs.push_back('{5'b10101, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1});
        vecs.push_back('{5'b10101, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1});
        vecs.push_back('{5'b10101, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1});
        vecs.push_back('{5'b10101, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1});
        vecs.push_back('{5'b10101, 32'h4B00_0000, 32'h0080_0000, 1'b0, 2});
        vecs.push_back('{5'b10101, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1});
        vecs.push_back('{5'b10100, 32'h4F7F_FFFF, 32'hFFFF_FF00, 1'b0, 10});
        vecs.push_back('{5'b10111, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33});
        vecs.push_back('{5'b10110, 32'h0100_0001, 32'h4B80_0000, 1'b0, 9});
        vecs.push_back('{5'b10110, 32'h0100_0003, 32'h4B80_0002, 1'b0, 9});

        rst_n       = 1'b0;
        start       = 1'b0;
        alu_control = 5'd0;
        src_a       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {result, 27'd0, stall, busy, done, invalid, 1'b0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].src,
                     vecs[i].res, vecs[i].inv, vecs[i].lat);
        end

        // Reset in cycle 5 of a long int->float conversion.
        @(negedge clk);
        start       = 1'b1;
        alu_control = 5'b10111;
        src_a       = 32'h0000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", {result, 27'd0, stall, busy, done, invalid, 1'b0}, 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        lat_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) lat_seen++;
        end
        chk("abort_no_done", 32'(lat_seen), 32'd0);

        // Start with a non-conversion code.
        @(negedge clk);
        start       = 1'b1;
        alu_control = 5'b00000;
        src_a       = 32'h3F80_0000;
        #1;
        chk("nonconv_stall", {31'd0, stall}, 32'd0);
        err = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) err++;
        end
        chk("nonconv_idle", 32'(err), 32'd0);
        start = 1'b0;

        // start held high while busy and through DONE must not disturb the running conversion.
        @(negedge clk);
        start       = 1'b1;
        alu_control = 5'b10101;
        src_a       = 32'hC049_0FDB;
        @(posedge clk);
        #1;
        alu_control = 5'b10111;
        src_a       = 32'h0000_0001;
        lat_seen    = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat_seen = c;
                break;
            end
        end
        chk("busy_start_latency", 32'(lat_seen), 32'd24);
        chk("busy_start_result", result, 32'hFFFF_FFFD);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", {29'd0, busy, stall, done}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            r_ctl = {3'b101, 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 3))
                0: r_src = $urandom;
                1: r_src = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 162)), 23'($urandom)};
                2: begin
                    r_src = 32'($urandom_range(0, 1000));
                    if ($urandom_range(0, 1) == 1) r_src = -r_src;
                end
                default: r_src = 32'd1 << $urandom_range(0, 31);
            endcase
            model(r_ctl, r_src, m_res, m_inv, m_lat);
            run_conv($sformatf("rnd%0d_%b_%h", i, r_ctl, r_src), r_ctl, r_src, m_res, m_inv, m_lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
